// File: rtl/axis64_rx_pkt_buffer_if.sv
// 64-bit AXI-Stream bundle carrying MAC beats (data, byte enables, sideband, last).
interface axis64_rx_pkt_buffer_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic [63:0] tuser;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis64_rx_pkt_buffer.sv
// Store-and-forward MAC->KVS packet buffer: whole packets are committed or dropped,
// and only committed packets are streamed out through a 2-entry skid stage.
module axis64_rx_pkt_buffer #(
  parameter int DEPTH_LOG2 = 9,
  parameter int CNT_W      = 32
) (
  input  logic                    clk_390,
  input  logic                    clk_390_rst,
  axis64_rx_pkt_buffer_if.slave   in_s,
  axis64_rx_pkt_buffer_if.master  out_m,
  output logic [CNT_W-1:0]        stat_pkt_ok,
  output logic [CNT_W-1:0]        stat_pkt_drop,
  output logic [DEPTH_LOG2:0]     stat_occupancy
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int EW    = 137;

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wstate_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [EW-1:0]   mem [DEPTH];
  wstate_t         wst_q;
  logic [PW-1:0]   wr_ptr_q, wr_commit_q, rd_ptr_q;
  logic [CNT_W-1:0] ok_q, drop_q;
  logic [PW-1:0]   occ_q;
  logic            ready_q;
  logic [1:0]      cnt_q, cnt_d;
  logic [EW-1:0]   e0_q, e1_q;

  logic [PW-1:0] used;
  logic          xfer, full, wr_en, avail, pop, issue;
  logic          load_e0_mem, load_e0_e1, load_e1_mem;

  // One slot is held back so that a packet of DEPTH beats can never commit.
  assign used  = wr_ptr_q - rd_ptr_q;
  assign full  = used >= PW'(DEPTH - 1);
  assign xfer  = in_s.tvalid & ready_q;
  assign wr_en = xfer & ~full & (wst_q != W_DROP);
  assign avail = rd_ptr_q != wr_commit_q;

  assign pop   = (cnt_q != 2'd0) & out_m.tready;
  assign issue = avail & ((cnt_q != 2'd2) | out_m.tready);

  always_comb begin
    load_e0_e1  = pop && (cnt_q == 2'd2);
    load_e0_mem = issue && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop));
    load_e1_mem = issue && (((cnt_q == 2'd1) && !pop) || ((cnt_q == 2'd2) && pop));
    cnt_d       = cnt_q + {1'b0, issue} - {1'b0, pop};
  end

  always_ff @(posedge clk_390 or posedge clk_390_rst) begin
    if (clk_390_rst) begin
      wst_q       <= W_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      ok_q        <= '0;
      drop_q      <= '0;
      ready_q     <= 1'b0;
      occ_q       <= '0;
    end else begin
      ready_q <= 1'b1;
      occ_q   <= used;
      if (xfer) begin
        case (wst_q)
          W_IDLE, W_PKT: begin
            if (!full) begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
              if (in_s.tlast) begin
                wr_commit_q <= wr_ptr_q + 1'b1;
                ok_q        <= sat_inc(ok_q);
                wst_q       <= W_IDLE;
              end else begin
                wst_q <= W_PKT;
              end
            end else begin
              // Roll back the partial packet; the rest of it is discarded.
              wr_ptr_q <= wr_commit_q;
              if (in_s.tlast) begin
                drop_q <= sat_inc(drop_q);
                wst_q  <= W_IDLE;
              end else begin
                wst_q <= W_DROP;
              end
            end
          end
          W_DROP: begin
            if (in_s.tlast) begin
              drop_q <= sat_inc(drop_q);
              wst_q  <= W_IDLE;
            end
          end
          default: wst_q <= W_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_390) begin
    if (wr_en)
      mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {in_s.tuser, in_s.tkeep, in_s.tlast, in_s.tdata};
  end

  // RAM read lands directly in the skid stage, giving tlast-to-tvalid of two cycles.
  always_ff @(posedge clk_390 or posedge clk_390_rst) begin
    if (clk_390_rst) begin
      rd_ptr_q <= '0;
      cnt_q    <= 2'd0;
      e0_q     <= '0;
      e1_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (issue)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (load_e0_e1)
        e0_q <= e1_q;
      else if (load_e0_mem)
        e0_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
      if (load_e1_mem)
        e1_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    end
  end

  assign in_s.tready    = ready_q;
  assign out_m.tvalid   = cnt_q != 2'd0;
  assign out_m.tdata    = e0_q[63:0];
  assign out_m.tlast    = e0_q[64];
  assign out_m.tkeep    = e0_q[72:65];
  assign out_m.tuser    = e0_q[136:73];
  assign stat_pkt_ok    = ok_q;
  assign stat_pkt_drop  = drop_q;
  assign stat_occupancy = occ_q;
endmodule

// File: tb/tb_axis64_rx_pkt_buffer.sv
// Directed bench for axis64_rx_pkt_buffer with a 16-beat buffer and an in-order packet scoreboard.
module tb_axis64_rx_pkt_buffer;
  localparam int DL = 4;
  localparam int CW = 32;
  localparam int NRAND = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis64_rx_pkt_buffer_if in_if ();
  axis64_rx_pkt_buffer_if out_if ();

  logic [CW-1:0] ok, drop;
  logic [DL:0]   occ;

  axis64_rx_pkt_buffer #(.DEPTH_LOG2(DL), .CNT_W(CW)) dut (
    .clk_390        (clk),
    .clk_390_rst    (rst),
    .in_s           (in_if),
    .out_m          (out_if),
    .stat_pkt_ok    (ok),
    .stat_pkt_drop  (drop),
    .stat_occupancy (occ)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic [63:0] u;
    logic        l;
    int          cyc;
  } beat_t;

  beat_t cap[$];
  int    cyc = 0;
  int    compared = 0;
  int    mismatched = 0;
  int    plen [NRAND];
  bit    done5 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // A beat seen valid&ready at the falling edge transfers on the next rising edge.
  always @(negedge clk)
    if (!rst && out_if.tvalid && out_if.tready)
      cap.push_back('{d: out_if.tdata, k: out_if.tkeep, u: out_if.tuser, l: out_if.tlast, cyc: cyc});

  function automatic logic [63:0] mk_d(input int p, input int b, input int len);
    return {p[31:0], b[15:0], len[15:0]};
  endfunction
  function automatic logic [7:0] mk_k(input int p, input int b, input int len);
    return (b == len - 1) ? (8'(p * 7 + 3) | 8'h01) : 8'hFF;
  endfunction
  function automatic logic [63:0] mk_u(input int p, input int b);
    return {~p, 32'(b * 3 + 1)};
  endfunction
  function automatic bit beat_ok(input beat_t x, input int p, input int b, input int len);
    return x.d === mk_d(p, b, len) && x.k === mk_k(p, b, len) &&
           x.u === mk_u(p, b) && x.l === (b == len - 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic [63:0] u, input logic l);
    in_if.tdata  = d;
    in_if.tkeep  = k;
    in_if.tuser  = u;
    in_if.tlast  = l;
    in_if.tvalid = 1'b1;
    step();
    in_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int p, input int len, input bit gaps);
    for (int b = 0; b < len; b++) begin
      beat(mk_d(p, b, len), mk_k(p, b, len), mk_u(p, b), b == len - 1);
      if (gaps && $urandom_range(0, 3) == 0) step();
    end
  endtask

  task automatic wait_cap(input int n, input int budget, input string tag);
    int i = 0;
    while (cap.size() < n && i < budget) begin
      step();
      i++;
    end
    check(tag, 64'(cap.size() >= n), 64'd1);
  endtask

  initial begin
    int base, bad, nb, idx, lastp, npk, p, len;
    logic [CW-1:0] ok0, dr0;
    in_if.tdata = '0; in_if.tkeep = '0; in_if.tuser = '0; in_if.tlast = 1'b0; in_if.tvalid = 1'b0;
    out_if.tready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_tready", 64'(in_if.tready), 64'd0);
    check("rst_out_tvalid", 64'(out_if.tvalid), 64'd0);
    check("rst_out_tdata", out_if.tdata, 64'd0);
    check("rst_stat_ok", 64'(ok), 64'd0);
    check("rst_stat_drop", 64'(drop), 64'd0);
    check("rst_occ", 64'(occ), 64'd0);
    rst = 1'b0;
    step();
    check("in_tready_after_rst", 64'(in_if.tready), 64'd1);

    // 1: single-beat packet, two-cycle latency
    out_if.tready = 1'b1;
    base = cap.size();
    beat(64'h1122334455667788, 8'hFF, 64'd0, 1'b1);
    check("t1_valid_n1", 64'(out_if.tvalid), 64'd0);
    step();
    check("t1_valid_n2", 64'(out_if.tvalid), 64'd1);
    check("t1_tdata", out_if.tdata, 64'h1122334455667788);
    check("t1_tkeep", 64'(out_if.tkeep), 64'hFF);
    check("t1_tlast", 64'(out_if.tlast), 64'd1);
    check("t1_stat_ok", 64'(ok), 64'd1);
    check("t1_occ", 64'(occ), 64'd1);
    step();
    check("t1_count", 64'(cap.size() - base), 64'd1);
    check("t1_valid_n3", 64'(out_if.tvalid), 64'd0);

    // 2: 100 back-to-back 8-beat packets
    base = cap.size();
    for (int i = 1; i <= 100; i++) send_pkt(i, 8, 1'b0);
    wait_cap(base + 800, 100, "t2_wait");
    bad = 0; nb = 0;
    for (int i = 0; i < 800 && base + i < cap.size(); i++) begin
      if (!beat_ok(cap[base + i], 1 + i / 8, i % 8, 8)) bad++;
      if (cap[base + i].cyc != cap[base].cyc + i) nb++;
    end
    check("t2_content", 64'(bad), 64'd0);
    check("t2_bubbles", 64'(nb), 64'd0);
    check("t2_stat_drop", 64'(drop), 64'd0);
    check("t2_stat_ok", 64'(ok), 64'd101);

    // 3: three 6-beat packets into a stalled 16-beat buffer
    repeat (4) step();
    out_if.tready = 1'b0;
    base = cap.size(); ok0 = ok; dr0 = drop;
    for (int i = 201; i <= 203; i++) send_pkt(i, 6, 1'b0);
    repeat (5) step();
    check("t3_drop", 64'(drop - dr0), 64'd1);
    check("t3_ok", 64'(ok - ok0), 64'd2);
    check("t3_occ", 64'(occ), 64'd10);
    check("t3_held_valid", 64'(out_if.tvalid), 64'd1);
    check("t3_held_data", out_if.tdata, mk_d(201, 0, 6));
    out_if.tready = 1'b1;
    repeat (40) step();
    check("t3_count", 64'(cap.size() - base), 64'd12);
    bad = 0;
    for (int i = 0; i < 12 && base + i < cap.size(); i++)
      if (!beat_ok(cap[base + i], 201 + i / 6, i % 6, 6)) bad++;
    check("t3_content", 64'(bad), 64'd0);

    // 4: DEPTH-beat packet dropped, next short packet intact
    base = cap.size(); ok0 = ok; dr0 = drop;
    send_pkt(301, 16, 1'b0);
    send_pkt(302, 2, 1'b0);
    repeat (20) step();
    check("t4_drop", 64'(drop - dr0), 64'd1);
    check("t4_ok", 64'(ok - ok0), 64'd1);
    check("t4_count", 64'(cap.size() - base), 64'd2);
    bad = 0;
    for (int i = 0; i < 2 && base + i < cap.size(); i++)
      if (!beat_ok(cap[base + i], 302, i, 2)) bad++;
    check("t4_content", 64'(bad), 64'd0);

    // 5: random lengths, random out_tready, pointer wrap
    base = cap.size(); ok0 = ok; dr0 = drop;
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          plen[i] = $urandom_range(1, 20);
          send_pkt(1000 + i, plen[i], 1'b1);
        end
        done5 = 1'b1;
      end
      begin
        while (!done5) begin
          out_if.tready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    out_if.tready = 1'b1;
    repeat (60) step();
    idx = base; lastp = 999; npk = 0; bad = 0;
    while (idx < cap.size()) begin
      p = int'(cap[idx].d[63:32]);
      if (p <= lastp || p >= 1000 + NRAND) begin
        bad++;
        break;
      end
      len = plen[p - 1000];
      if (len >= 16) bad++;
      for (int b = 0; b < len; b++) begin
        if (idx >= cap.size()) begin
          bad++;
          break;
        end
        if (!beat_ok(cap[idx], p, b, len)) bad++;
        idx++;
      end
      lastp = p;
      npk++;
    end
    check("t5_content", 64'(bad), 64'd0);
    check("t5_ok_vs_received", 64'(ok - ok0), 64'(npk));
    check("t5_ok_plus_drop", 64'((ok - ok0) + (drop - dr0)), 64'(NRAND));
    check("t5_drained_valid", 64'(out_if.tvalid), 64'd0);
    check("t5_drained_occ", 64'(occ), 64'd0);

    // 6: reset mid-packet with packets buffered
    out_if.tready = 1'b0;
    for (int i = 401; i <= 403; i++) send_pkt(i, 2, 1'b0);
    beat(mk_d(404, 0, 4), mk_k(404, 0, 4), mk_u(404, 0), 1'b0);
    beat(mk_d(404, 1, 4), mk_k(404, 1, 4), mk_u(404, 1), 1'b0);
    check("t6_pre_valid", 64'(out_if.tvalid), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(out_if.tvalid), 64'd0);
    check("t6_rst_tdata", out_if.tdata, 64'd0);
    check("t6_rst_ok", 64'(ok), 64'd0);
    check("t6_rst_drop", 64'(drop), 64'd0);
    check("t6_rst_occ", 64'(occ), 64'd0);
    check("t6_rst_tready", 64'(in_if.tready), 64'd0);
    step();
    rst = 1'b0;
    step();
    check("t6_tready_back", 64'(in_if.tready), 64'd1);
    out_if.tready = 1'b1;
    base = cap.size();
    beat(mk_d(405, 0, 1), mk_k(405, 0, 1), mk_u(405, 0), 1'b1);
    check("t6_valid_n1", 64'(out_if.tvalid), 64'd0);
    step();
    check("t6_valid_n2", 64'(out_if.tvalid), 64'd1);
    check("t6_tdata_n2", out_if.tdata, mk_d(405, 0, 1));
    repeat (10) step();
    check("t6_count", 64'(cap.size() - base), 64'd1);
    check("t6_stat_ok", 64'(ok), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
